add_simd_ctrl: RTL

//  Sequencer for the add_simd residual-add datapath. Pops operand pairs from two

---
 rtl/add_simd_ctrl_pkg.sv | 24 ++
 rtl/add_simd_ctrl_lat_pipe.sv | 36 +++
 rtl/add_simd_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/add_simd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : add_simd_ctrl_pkg
// Brief    : Shared constants for the add_simd sequencer: datapath sizes,
//            per-type adder latencies and FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package add_simd_ctrl_pkg;

    localparam int c_PICTURE_NUM    = 8;
    localparam int c_WIDTH_DATA_OUT = 16;

    // Pipeline depth of the add_simd variants (add_16_16 / Add_34_34)
    localparam int c_ADD_LATENCY_T1 = 2;
    localparam int c_ADD_LATENCY_T2 = 3;

    localparam int c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_IDLE  = 2'd0;
    localparam logic [c_STATE_W-1:0] c_RUN   = 2'd1;
    localparam logic [c_STATE_W-1:0] c_DRAIN = 2'd2;
    localparam logic [c_STATE_W-1:0] c_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/add_simd_ctrl_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module   : add_lat_pipe
// Brief    : DEPTH-stage single-bit shift register tracking a pipelined op's
//            latency; asynchronous active-high reset clears every stage.
// Revision : 1.0 - initial release
// ============================================================================
module add_lat_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    generate
        if (DEPTH == 1) begin : g_single
            logic r_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_q <= 1'b0;
                else     r_q <= in;
            end
            assign out = r_q;
        end else begin : g_shift
            logic [DEPTH-1:0] r_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_q <= '0;
                else     r_q <= {r_q[DEPTH-2:0], in};
            end
            assign out = r_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/add_simd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : add_simd_ctrl
// Brief    : Pops operand pairs into add_simd and writes its sums to the
//            output FIFO, one tile of beat_num beats per start.
//            Optional macro ADD_SIMD_PERF_EN adds stall_cnt / issue_cnt ports.
// Revision : 1.0 - initial release
// ============================================================================
module add_simd_ctrl
    import add_simd_ctrl_pkg::*;
#(
    parameter int RD_LAT      = 1,
    parameter int ADD_LATENCY = c_ADD_LATENCY_T1,
    parameter int CNT_W       = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] beat_num,
    output logic             busy,
    output logic             done,
    input  logic             one_empty,
    input  logic             two_empty,
    output logic             one_rd_en,
    output logic             two_rd_en,
    input  logic             out_afull,
    output logic             out_wr_en
`ifdef ADD_SIMD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] issue_cnt
`endif
);

    localparam int               c_PIPE_L = RD_LAT + ADD_LATENCY;
    localparam logic [CNT_W-1:0] c_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [CNT_W-1:0]     r_beat_num;
    logic [CNT_W-1:0]     r_issued;
    logic [CNT_W-1:0]     r_written;
    logic                 w_start_ok;
    logic                 w_issue;
    logic                 w_last_issue;
    logic                 w_last_write;

    assign w_start_ok   = start && (r_state == c_IDLE);
    assign w_issue      = (r_state == c_RUN) && !one_empty && !two_empty &&
                          !out_afull && (r_issued < r_beat_num);
    assign w_last_issue = w_issue && ((r_issued + c_ONE) == r_beat_num);
    assign w_last_write = out_wr_en && ((r_written + c_ONE) == r_beat_num);

    // Both FIFOs are always popped together so operand pairs stay aligned
    assign one_rd_en = w_issue;
    assign two_rd_en = w_issue;
    assign busy      = (r_state != c_IDLE);
    assign done      = (r_state == c_DONE);

    add_lat_pipe #(
        .DEPTH (c_PIPE_L)
    ) u_lat_pipe (
        .clk (clk),
        .rst (rst),
        .in  (w_issue),
        .out (out_wr_en)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_nxt = (beat_num == '0) ? c_DONE : c_RUN;
            c_RUN:   if (w_last_issue) w_state_nxt = c_DRAIN;
            c_DRAIN: if (w_last_write) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_num <= '0;
            r_issued   <= '0;
            r_written  <= '0;
        end else if (w_start_ok) begin
            r_beat_num <= beat_num;
            r_issued   <= '0;
            r_written  <= '0;
        end else begin
            if (w_issue)   r_issued  <= r_issued + c_ONE;
            if (out_wr_en) r_written <= r_written + c_ONE;
        end
    end

`ifdef ADD_SIMD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_issue_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_issue_cnt <= '0;
        end else if (w_start_ok) begin
            r_stall_cnt <= '0;
            r_issue_cnt <= '0;
        end else begin
            if ((r_state == c_RUN) && !w_issue && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + c_ONE;
            if (w_issue && (r_issue_cnt != '1))
                r_issue_cnt <= r_issue_cnt + c_ONE;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign issue_cnt = r_issue_cnt;
`endif

endmodule
`default_nettype wire
